// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/breakpoint controller for the single-cycle CPU.
// Produces a one-clk-wide clock enable (cpu_ce) for free run at two speeds,
// debounced single-step, and an optional PC breakpoint.
// The breakpoint logic is built only when CPU_RUN_CTRL_BP_EN is defined;
// otherwise bp_en/bp_addr/pc are ignored and brk stays 0.
module cpu_run_ctrl #(
  parameter int unsigned DIV_FAST  = 33554432,
  parameter int unsigned DIV_SLOW  = 134217728,
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned PC_W      = 6,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             speed_sel,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_ce,
  output logic             halted,
  output logic             brk,
  output logic [CNT_W-1:0] step_count
);

  localparam int unsigned DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int unsigned DIV_W   = $clog2(DIV_MAX + 1);
  localparam int unsigned DB_W    = $clog2(DB_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BREAK = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [DIV_W-1:0]   div_cnt, div_nx, period_m1;
  logic               ce_nx, brk_nx;

  logic               run_s1, run_s2, run_prev, run_rise;
  logic               btn_s1, btn_s2;
  logic [DB_W-1:0]    db_cnt;
  logic               db_state, db_prev, step_req;
  logic               bp_hit;

  // Two-flop synchronizers for the switch and button, plus run edge history
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_s1   <= 1'b0;
      run_s2   <= 1'b0;
      run_prev <= 1'b0;
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
    end else begin
      run_s1   <= run_sw;
      run_s2   <= run_s1;
      run_prev <= run_s2;
      btn_s1   <= step_btn;
      btn_s2   <= btn_s1;
    end
  end

  // run_prev resets low, so a switch held on through reset still yields a rise
  assign run_rise = run_s2 & ~run_prev;

  // Debounce: counter runs only while the synced button disagrees with db_state;
  // any return to agreement clears it. step_req is a registered rising-edge pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      db_cnt   <= '0;
      db_state <= 1'b0;
      db_prev  <= 1'b0;
      step_req <= 1'b0;
    end else begin
      db_prev  <= db_state;
      step_req <= db_state & ~db_prev;
      if (btn_s2 == db_state) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
        db_state <= btn_s2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Step period is re-sampled every cycle; the >= test absorbs a mid-count change
  assign period_m1 = speed_sel ? DIV_W'(DIV_SLOW - 1) : DIV_W'(DIV_FAST - 1);

`ifdef CPU_RUN_CTRL_BP_EN
  assign bp_hit = bp_en && (pc == bp_addr);
`else
  logic bp_unused;
  assign bp_hit    = 1'b0;
  assign bp_unused = ^{bp_en, bp_addr, pc};
`endif

  // Next-state, divider and pulse decision
  always_comb begin
    state_nx = state;
    div_nx   = div_cnt;
    ce_nx    = 1'b0;
    unique case (state)
      ST_HALT: begin
        if (run_rise) begin
          state_nx = ST_RUN;
          div_nx   = '0;
        end else if (step_req) begin
          ce_nx = 1'b1;
        end
      end
      ST_RUN: begin
        if (!run_s2) begin
          state_nx = ST_HALT;
          div_nx   = '0;
        end else if (div_cnt >= period_m1) begin
          div_nx = '0;
          if (bp_hit) state_nx = ST_BREAK;
          else        ce_nx    = 1'b1;
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end
      ST_BREAK: begin
        if (!run_s2) begin
          state_nx = ST_HALT;
        end else if (step_req) begin
          ce_nx    = 1'b1;
          state_nx = ST_HALT;
        end
      end
      default: begin
        state_nx = ST_HALT;
        div_nx   = '0;
      end
    endcase
  end

`ifdef CPU_RUN_CTRL_BP_EN
  assign brk_nx = (state_nx == ST_BREAK);
`else
  assign brk_nx = 1'b0;
`endif

  // State register with registered outputs and pulse counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_HALT;
      div_cnt    <= '0;
      cpu_ce     <= 1'b0;
      halted     <= 1'b1;
      brk        <= 1'b0;
      step_count <= '0;
    end else begin
      state   <= state_nx;
      div_cnt <= div_nx;
      cpu_ce  <= ce_nx;
      halted  <= (state_nx != ST_RUN);
      brk     <= brk_nx;
      if (ce_nx) step_count <= step_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed scenarios plus random stimulus for cpu_run_ctrl,
// checked every cycle against a time-indexed behavioural model.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;

  localparam int PF  = 4;
  localparam int PS  = 8;
  localparam int DBC = 3;
  localparam int PCW = 6;
  localparam int CW  = 8;   // narrow counter so wrap-around is reachable quickly
  localparam int HE  = 16384;
`ifdef CPU_RUN_CTRL_BP_EN
  localparam bit BP_BUILD = 1'b1;
`else
  localparam bit BP_BUILD = 1'b0;
`endif
  localparam int M_HALT = 0;
  localparam int M_RUN  = 1;
  localparam int M_BRK  = 2;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           run_sw = 1'b0;
  logic           step_btn = 1'b0;
  logic           speed_sel = 1'b0;
  logic           bp_en = 1'b0;
  logic [PCW-1:0] bp_addr = '0;
  logic [PCW-1:0] pc = '0;
  logic           pc_clr = 1'b1;
  logic           cpu_ce, halted, brk;
  logic [CW-1:0]  step_count;

  int tests = 0;
  int fails = 0;

  cpu_run_ctrl #(
    .DIV_FAST (PF),
    .DIV_SLOW (PS),
    .DB_CYCLES(DBC),
    .PC_W     (PCW),
    .CNT_W    (CW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .run_sw    (run_sw),
    .step_btn  (step_btn),
    .speed_sel (speed_sel),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc        (pc),
    .cpu_ce    (cpu_ce),
    .halted    (halted),
    .brk       (brk),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Stand-in for the datapath PC: advances on the edge that consumes cpu_ce
  always @(posedge clk) begin
    if (pc_clr)      pc <= '0;
    else if (cpu_ce) pc <= pc + 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Histories indexed by clock edge since reset release. Synchronized value at
  // edge k is the raw value sampled at edge k-2; the debounced level flips once
  // the synced button has disagreed with it for DBC consecutive edges.
  bit            run_h [HE];
  bit            btn_h [HE];
  bit            db_h  [HE];
  int            e = 0;
  int            m_mode = M_HALT;
  int            m_start = 0;
  bit            m_db = 1'b0;
  bit            exp_ce = 1'b0;
  bit            exp_halted = 1'b1;
  bit            exp_brk = 1'b0;
  logic [CW-1:0] exp_cnt = '0;

  function automatic bit raw_run(input int k);
    return (k >= 0) ? run_h[k % HE] : 1'b0;
  endfunction
  function automatic bit raw_btn(input int k);
    return (k >= 0) ? btn_h[k % HE] : 1'b0;
  endfunction
  function automatic bit db_after(input int k);
    return (k >= 0) ? db_h[k % HE] : 1'b0;
  endfunction

  always @(posedge clk) begin : model
    bit s_run, rise, sreq, flip, hit;
    int period;
    if (!rstn) begin
      e = 0; m_mode = M_HALT; m_start = 0; m_db = 1'b0;
      exp_ce = 1'b0; exp_halted = 1'b1; exp_brk = 1'b0; exp_cnt = '0;
    end else begin
      run_h[e % HE] = run_sw;
      btn_h[e % HE] = step_btn;
      s_run = raw_run(e - 2);
      rise  = s_run && !raw_run(e - 3);
      sreq  = db_after(e - 2) && !db_after(e - 3);
      flip  = 1'b1;
      for (int i = 0; i < DBC; i++) begin
        if (e - i < 0) flip = 1'b0;
        else if (raw_btn(e - i - 2) == m_db) flip = 1'b0;
      end
      if (flip) m_db = !m_db;
      db_h[e % HE] = m_db;
      period = speed_sel ? PS : PF;
      hit    = BP_BUILD && bp_en && (pc == bp_addr);
      exp_ce = 1'b0;
      case (m_mode)
        M_HALT: begin
          if (rise) begin m_mode = M_RUN; m_start = e + 1; end
          else if (sreq) exp_ce = 1'b1;
        end
        M_RUN: begin
          if (!s_run) m_mode = M_HALT;
          else if (e - m_start >= period - 1) begin
            m_start = e + 1;
            if (hit) m_mode = M_BRK;
            else     exp_ce = 1'b1;
          end
        end
        M_BRK: begin
          if (!s_run) m_mode = M_HALT;
          else if (sreq) begin exp_ce = 1'b1; m_mode = M_HALT; end
        end
        default: m_mode = M_HALT;
      endcase
      exp_halted = (m_mode != M_RUN);
      exp_brk    = (m_mode == M_BRK);
      if (exp_ce) exp_cnt = exp_cnt + 1'b1;
      e++;
    end
  end

  // Per-cycle comparison against the model, just after the active edge
  always @(posedge clk) begin
    #1;
    check("cpu_ce",     cpu_ce,     exp_ce);
    check("halted",     halted,     exp_halted);
    check("brk",        brk,        exp_brk);
    check("step_count", step_count, exp_cnt);
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_pulse(input string name, input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (cpu_ce === 1'b1) begin n = i; return; end
    end
    tests++; fails++;
    $display("FAIL %s: no cpu_ce within %0d cycles", name, budget);
  endtask

  task automatic count_pulses(input int cycles, output int c);
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (cpu_ce === 1'b1) c++;
    end
  endtask

  task automatic pulse_reset(input bit run_level);
    rstn = 1'b0; pc_clr = 1'b1; run_sw = run_level; step_btn = 1'b0;
    @(negedge clk);
    rstn = 1'b1; pc_clr = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    fails++;
    $display("FAIL watchdog: time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, c, lat;
    repeat (3) @(negedge clk);
    check("reset_cpu_ce", cpu_ce, 0);
    check("reset_halted", halted, 1);
    check("reset_brk", brk, 0);
    check("reset_step_count", step_count, 0);

    // Free run at fast speed
    rstn = 1'b1; pc_clr = 1'b0; run_sw = 1'b1;
    wait_pulse("first_pulse", 20, n);
    check("first_pulse_latency", n, 7);
    for (int k = 0; k < 4; k++) begin
      wait_pulse("fast_gap", 12, n);
      check("fast_gap", n, 4);
    end
    check("step_count_5", step_count, 5);
    check("model_count_5", exp_cnt, 5);
    check("running_halted", halted, 0);

    // Speed change when the divider sits at 2
    @(negedge clk); @(negedge clk);
    speed_sel = 1'b1;
    wait_pulse("speed_switch", 16, n);
    check("speed_switch_gap", n + 2, 8);
    wait_pulse("slow_gap", 16, n);
    check("slow_gap", n, 8);

    // Bouncing button in HALT gives exactly one step
    speed_sel = 1'b0;
    pulse_reset(1'b0);
    repeat (4) @(negedge clk);
    c = 0;
    for (int k = 0; k < 4; k++) begin
      step_btn = (k % 2 == 0);
      @(negedge clk);
      if (cpu_ce === 1'b1) c++;
    end
    step_btn = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (cpu_ce === 1'b1) begin c++; if (lat == 0) lat = i; end
    end
    check("button_latency", lat, 7);
    step_btn = 1'b0;
    count_pulses(12, n);
    check("bounce_pulses", c + n, 1);
    check("step_count_after_step", step_count, 1);
    check("step_halted", halted, 1);

    // Breakpoint at PC 3
    pulse_reset(1'b0);
    bp_en = 1'b1; bp_addr = 6'd3; run_sw = 1'b1;
    count_pulses(40, c);
`ifdef CPU_RUN_CTRL_BP_EN
    check("bp_pulses", c, 3);
    check("bp_brk", brk, 1);
    check("bp_halted", halted, 1);
    check("bp_pc", pc, 3);
    step_btn = 1'b1;
    count_pulses(10, c);
    step_btn = 1'b0;
    count_pulses(10, n);
    check("bp_step_pulses", c + n, 1);
    check("bp_step_pc", pc, 4);
    check("bp_step_halted", halted, 1);
    check("bp_step_brk", brk, 0);
`else
    check("nobp_pulses", c, 9);
    check("nobp_brk", brk, 0);
    check("nobp_halted", halted, 0);
`endif
    run_sw = 1'b0;
    repeat (5) @(negedge clk);
    run_sw = 1'b1;
    repeat (5) @(negedge clk);
    check("resume_halted", halted, 0);
    bp_en = 1'b0;

    // Switch off landing on a terminal count
    wait_pulse("align1", 16, n);
    wait_pulse("align2", 16, n);
    @(negedge clk);
    run_sw = 1'b0;
    count_pulses(3, c);
    check("stop_on_terminal_pulses", c, 0);
    check("stop_on_terminal_halted", halted, 1);

    // Step counter wrap
    pulse_reset(1'b1);
    for (int k = 1; k <= 256; k++) begin
      wait_pulse("wrap_run", 12, n);
      if (k == 255) check("count_all_ones", step_count, 255);
      if (k == 256) check("count_wrap", step_count, 0);
    end

    // Reset while a pulse is in flight
    wait_pulse("pre_reset", 12, n);
    rstn = 1'b0;
    #1;
    check("midrun_reset_ce", cpu_ce, 0);
    check("midrun_reset_halted", halted, 1);
    check("midrun_reset_brk", brk, 0);
    check("midrun_reset_count", step_count, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Random stimulus, checked cycle by cycle by the model
    bp_addr = 6'd2;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 7) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 59) == 0) speed_sel = ~speed_sel;
      if ($urandom_range(0, 49) == 0) bp_en = ~bp_en;
      if ($urandom_range(0, 99) == 0) bp_addr = PCW'($urandom_range(0, 7));
      rstn = ($urandom_range(0, 999) != 0);
    end
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
